// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready flow control.
// Define FP_ADD_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_sum,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_ovf,
  output logic                   out_unf
);

  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned MW  = MAN_W + 4;         // hidden, frac, guard, round, sticky
  localparam int unsigned SW  = MAN_W + 5;         // MW plus carry
  localparam int unsigned LZW = $clog2(SW) + 1;
  localparam int unsigned EW  = EXP_W + LZW + 1;   // wide enough to hold negative exponents

`ifdef FP_ADD_RNE_EN
  localparam bit RneEn = 1'b1;
`else
  localparam bit RneEn = 1'b0;
`endif

  // Pipeline registers
  logic                 s1_valid_q, s1_sign_q, s1_sub_q;
  logic [EXP_W-1:0]     s1_exp_q;
  logic [MW-1:0]        s1_man_l_q, s1_man_s_q;
  logic [TAG_W-1:0]     s1_tag_q;

  logic                 s2_valid_q, s2_sign_q;
  logic [EXP_W-1:0]     s2_exp_q;
  logic [SW-1:0]        s2_sum_q;
  logic [TAG_W-1:0]     s2_tag_q;

  logic                 out_valid_q, out_ovf_q, out_unf_q;
  logic [W-1:0]         out_sum_q;
  logic [TAG_W-1:0]     out_tag_q;

  logic advance, accept;

  assign advance  = !out_valid_q || out_ready;
  assign accept   = in_valid && advance;
  assign in_ready = advance;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack, effective sign, magnitude compare, align
  // ---------------------------------------------------------------------------
  logic             a_zero, b_zero, b_sign;
  logic [W-2:0]     a_mag, b_mag;
  logic [MW-1:0]    a_man, b_man, l_man, s_man, shifted;
  logic [EXP_W-1:0] l_exp, s_exp, diff;
  logic             l_sign, s_sign;
  logic             s1_sign_d, s1_sub_d;
  logic [EXP_W-1:0] s1_exp_d;
  logic [MW-1:0]    s1_man_l_d, s1_man_s_d;

  always_comb begin
    a_zero = (in_a[W-2:MAN_W] == '0);
    b_zero = (in_b[W-2:MAN_W] == '0);
    b_sign = in_b[W-1] ^ in_sub;
    // Exponent-zero inputs are flushed to a true zero magnitude.
    a_mag  = a_zero ? '0 : in_a[W-2:0];
    b_mag  = b_zero ? '0 : in_b[W-2:0];
    a_man  = a_zero ? '0 : {1'b1, in_a[MAN_W-1:0], 3'b000};
    b_man  = b_zero ? '0 : {1'b1, in_b[MAN_W-1:0], 3'b000};

    if (a_mag >= b_mag) begin
      l_sign = in_a[W-1];
      s_sign = b_sign;
      l_exp  = in_a[W-2:MAN_W];
      s_exp  = in_b[W-2:MAN_W];
      l_man  = a_man;
      s_man  = b_man;
    end else begin
      l_sign = b_sign;
      s_sign = in_a[W-1];
      l_exp  = in_b[W-2:MAN_W];
      s_exp  = in_a[W-2:MAN_W];
      l_man  = b_man;
      s_man  = a_man;
    end

    diff    = l_exp - s_exp;
    shifted = '0;
    if (32'(diff) >= MW) begin
      s1_man_s_d = {{(MW-1){1'b0}}, |s_man};
    end else begin
      shifted    = s_man >> diff;
      // Any bit shifted past the sticky position folds into it.
      s1_man_s_d = shifted | {{(MW-1){1'b0}}, ((shifted << diff) != s_man)};
    end

    s1_sign_d  = l_sign;
    s1_sub_d   = l_sign ^ s_sign;
    s1_exp_d   = l_exp;
    s1_man_l_d = l_man;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: mantissa add/sub (larger minus smaller, never negative)
  // ---------------------------------------------------------------------------
  logic [SW-1:0] s2_sum_d;

  always_comb begin
    if (s1_sub_q) begin
      s2_sum_d = {1'b0, s1_man_l_q} - {1'b0, s1_man_s_q};
    end else begin
      s2_sum_d = {1'b0, s1_man_l_q} + {1'b0, s1_man_s_q};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: leading-one detect, normalise, round, pack, flags
  // ---------------------------------------------------------------------------
  logic [LZW-1:0]   lz;
  logic [MW-1:0]    norm;
  logic [EW-1:0]    exp_base, exp_n, exp_r, exp_max;
  logic [MAN_W+1:0] rounded;
  logic [MAN_W-1:0] frac_r;
  logic             g, r, st, rnd_up;
  logic [W-1:0]     out_sum_d;
  logic             out_ovf_d, out_unf_d;

  always_comb begin
    lz = '0;
    for (int i = 0; i < int'(SW) - 1; i++) begin
      if (s2_sum_q[i]) lz = LZW'(int'(SW) - 2 - i);
    end
  end

  always_comb begin
    exp_base = {{(EW-EXP_W){1'b0}}, s2_exp_q};
    exp_max  = {{(EW-EXP_W){1'b0}}, {EXP_W{1'b1}}};

    if (s2_sum_q[SW-1]) begin
      norm  = {s2_sum_q[SW-1:2], |s2_sum_q[1:0]};
      exp_n = exp_base + EW'(1);
    end else begin
      norm  = s2_sum_q[SW-2:0] << lz;
      exp_n = exp_base - EW'(lz);
    end

    g       = norm[2];
    r       = norm[1];
    st      = norm[0];
    rnd_up  = RneEn & g & (r | st | norm[3]);
    rounded = {1'b0, norm[MW-1:3]} + (MAN_W+2)'(rnd_up);

    // Rounding carry-out: mantissa becomes 1.0, exponent bumps.
    if (rounded[MAN_W+1]) begin
      frac_r = rounded[MAN_W:1];
      exp_r  = exp_n + EW'(1);
    end else begin
      frac_r = rounded[MAN_W-1:0];
      exp_r  = exp_n;
    end

    out_sum_d = {s2_sign_q, exp_r[EXP_W-1:0], frac_r};
    out_ovf_d = 1'b0;
    out_unf_d = 1'b0;
    if (s2_sum_q == '0) begin
      out_sum_d = '0;
    end else if (!exp_r[EW-1] && (exp_r >= exp_max)) begin
      out_sum_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      out_ovf_d = 1'b1;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      out_sum_d = '0;
      out_unf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State: all stages move together on advance
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sub_q    <= 1'b0;
      s1_exp_q    <= '0;
      s1_man_l_q  <= '0;
      s1_man_s_q  <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_exp_q    <= '0;
      s2_sum_q    <= '0;
      s2_tag_q    <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_tag_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= accept;
      s1_sign_q   <= s1_sign_d;
      s1_sub_q    <= s1_sub_d;
      s1_exp_q    <= s1_exp_d;
      s1_man_l_q  <= s1_man_l_d;
      s1_man_s_q  <= s1_man_s_d;
      s1_tag_q    <= in_tag;
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_exp_q    <= s1_exp_q;
      s2_sum_q    <= s2_sum_d;
      s2_tag_q    <= s1_tag_q;
      out_valid_q <= s2_valid_q;
      out_sum_q   <= out_sum_d;
      out_tag_q   <= s2_tag_q;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_tag   = out_tag_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Bench for fp_add_pipe (fp32 configuration): vector table, scoreboard, stall and reset sequences.
module tb_fp_add_pipe;

`ifdef FP_ADD_RNE_EN
  localparam bit Rne = 1'b1;
`else
  localparam bit Rne = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic [3:0]  out_tag;
  logic        out_ovf, out_unf;

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  tag;
    logic        ovf;
    logic        unf;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] sum;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];
  exp_t drv_exp;
  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  logic        stall_q = 1'b0;
  logic [37:0] held_q = '0;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        checks++;
        if (!out_valid || {out_sum, out_tag, out_ovf, out_unf} != held_q) begin
          failures++;
          $display("FAIL hold_stable: got valid=%b out=%h, required valid=1 out=%h",
                   out_valid, {out_sum, out_tag, out_ovf, out_unf}, held_q);
        end
      end
      stall_q = out_valid && !out_ready;
      held_q  = {out_sum, out_tag, out_ovf, out_unf};
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got sum=%h tag=%0d, required no output", out_sum, out_tag);
        end else begin
          e = sb.pop_front();
          if (out_sum !== e.sum || out_tag !== e.tag || out_ovf !== e.ovf || out_unf !== e.unf) begin
            failures++;
            $display("FAIL result[%0d]: got sum=%h tag=%0d ovf=%b unf=%b, required sum=%h tag=%0d ovf=%b unf=%b",
                     pops, out_sum, out_tag, out_ovf, out_unf, e.sum, e.tag, e.ovf, e.unf);
          end
        end
        pops++;
      end
      if (in_valid && in_ready) sb.push_back(drv_exp);
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, input logic [3:0] tag);
    int n;
    in_a     = v.a;
    in_b     = v.b;
    in_sub   = v.sub;
    in_tag   = tag;
    drv_exp  = '{sum: v.sum, tag: tag, ovf: v.ovf, unf: v.unf};
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got in_ready=0, required 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic v_n1, v_n2;
    int   n;
    vec_t one;

    vecs.push_back('{a: 32'h3F800000, b: 32'h3F800000, sub: 1'b0, sum: 32'h40000000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h40400000, b: 32'h3F800000, sub: 1'b1, sum: 32'h40000000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h3F800000, b: 32'h3F800000, sub: 1'b1, sum: 32'h00000000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h7F7FFFFF, b: 32'h7F7FFFFF, sub: 1'b0, sum: 32'h7F800000, ovf: 1'b1, unf: 1'b0});
    vecs.push_back('{a: 32'h00800000, b: 32'h80800001, sub: 1'b0, sum: 32'h00000000, ovf: 1'b0, unf: 1'b1});
    vecs.push_back('{a: 32'h3F800000, b: 32'h33C00000, sub: 1'b0,
                     sum: Rne ? 32'h3F800001 : 32'h3F800000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h3F800000, b: 32'h33800000, sub: 1'b0, sum: 32'h3F800000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h00000000, b: 32'hC0A00000, sub: 1'b0, sum: 32'hC0A00000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h00000000, b: 32'h40A00000, sub: 1'b1, sum: 32'hC0A00000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h80000000, b: 32'h80000000, sub: 1'b0, sum: 32'h00000000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h00000001, b: 32'h3F800000, sub: 1'b0, sum: 32'h3F800000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h3F800000, b: 32'hBF000000, sub: 1'b0, sum: 32'h3F000000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h3F800000, b: 32'h40000000, sub: 1'b1, sum: 32'hBF800000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h3FC00000, b: 32'h3FC00000, sub: 1'b0, sum: 32'h40400000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h3FFFFFFF, b: 32'h33C00000, sub: 1'b0,
                     sum: Rne ? 32'h40000000 : 32'h3FFFFFFF, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'h7F7FFFFF, b: 32'h73400000, sub: 1'b0,
                     sum: Rne ? 32'h7F800000 : 32'h7F7FFFFF, ovf: Rne, unf: 1'b0});
    vecs.push_back('{a: 32'h3F800000, b: 32'h0B800000, sub: 1'b0, sum: 32'h3F800000, ovf: 1'b0, unf: 1'b0});
    vecs.push_back('{a: 32'hC0000000, b: 32'hC0000000, sub: 1'b0, sum: 32'hC0800000, ovf: 1'b0, unf: 1'b0});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_tag !== '0 || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: got valid=%b sum=%h tag=%0d ovf=%b unf=%b, required all 0",
               out_valid, out_sum, out_tag, out_ovf, out_unf);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Latency: one op into an empty pipe
    send(vecs[0], 4'd5);
    @(negedge clk);
    @(negedge clk);
    v_n1 = out_valid;
    @(negedge clk);
    v_n2 = out_valid;
    checks++;
    if (v_n1 !== 1'b0 || v_n2 !== 1'b1) begin
      failures++;
      $display("FAIL latency: got valid %b,%b after 2,3 edges, required 0,1", v_n1, v_n2);
    end
    @(posedge clk);
    #1;
    drain();

    // Full table, back-to-back
    for (int i = 0; i < vecs.size(); i++) send(vecs[i], 4'(i));
    drain();

    // Stall with six ops behind it
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vecs[i], 4'(i));
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (!out_valid) begin
          failures++;
          $display("FAIL stall_fill: got out_valid=0, required 1");
        end
        repeat (5) begin
          checks++;
          if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_ready: got in_ready=%b, required 0", in_ready);
          end
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        repeat (6) begin
          @(negedge clk);
          if (out_valid) n++;
        end
        checks++;
        if (n != 6) begin
          failures++;
          $display("FAIL stall_burst: got %0d valid cycles, required 6", n);
        end
      end
    join
    @(posedge clk);
    #1;
    drain();

    // Random backpressure over the table
    fork
      begin
        for (int i = 0; i < vecs.size(); i++) send(vecs[i], 4'(i));
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vecs[i], 4'(i + 8));
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_tag !== '0 || out_ovf !== 1'b0 ||
        out_unf !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_flush: got valid=%b sum=%h tag=%0d ovf=%b unf=%b rdy=%b, required 0s and rdy=1",
               out_valid, out_sum, out_tag, out_ovf, out_unf, in_ready);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL no_stale: got %0d valid cycles after reset, required 0", n);
    end
    @(posedge clk);
    #1;
    one = vecs[13];
    send(one, 4'd3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
